// File: rtl/uart_rx_deserializer.sv
// UART receive front end: synchronises the asynchronous RX pin and recovers
// 8N1 frames by mid-bit sampling. Each good byte is presented as a one-cycle
// strobe on o_valid. A stop bit sampled low is reported as a one-cycle
// o_frame_error strobe instead.
module uart_rx_deserializer #(
  parameter int CLKS_PER_BIT = 139
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_rx_unsafe,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_error,
  output logic       o_busy
);

  localparam int H  = (CLKS_PER_BIT - 1) / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);

  // Terminal counts: the cycle counter starts at 0 on the cycle after a
  // state entry, so the sample lands on count N-1.
  localparam logic [CW-1:0] HALF_LAST = CW'(H - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_STOP      = 3'd3;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

  logic          meta_q, meta_d;
  logic          rx_s_q, rx_s_d;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;

  // Next-state logic: synchroniser chain, frame FSM, counters and shifter.
  always_comb begin
    meta_d  = i_rx_unsafe;
    rx_s_d  = meta_q;
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!rx_s_q) begin
          state_d = ST_START;
          cyc_d   = '0;
        end
      end

      ST_START: begin
        if (cyc_q == HALF_LAST) begin
          if (!rx_s_q) begin
            state_d = ST_DATA;
            cyc_d   = '0;
            bit_d   = 3'd0;
          end else begin
            // Line went back high before mid start bit: false start.
            state_d = ST_IDLE;
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end

      ST_DATA: begin
        if (cyc_q == BIT_LAST) begin
          cyc_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            bit_d   = 3'd0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end

      ST_STOP: begin
        if (cyc_q == BIT_LAST) begin
          cyc_d = '0;
          if (rx_s_q) begin
            // Returning to IDLE at mid stop bit leaves half a bit of slack
            // for a back-to-back start edge.
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_WAIT_HIGH;
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end

      ST_WAIT_HIGH: begin
        // A held-low (break) line must not be decoded as repeated frames.
        if (rx_s_q) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset; synchroniser resets to idle-high.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      meta_q  <= 1'b1;
      rx_s_q  <= 1'b1;
      state_q <= ST_IDLE;
      cyc_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      meta_q  <= meta_d;
      rx_s_q  <= rx_s_d;
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign o_data        = data_q;
  assign o_valid       = valid_q;
  assign o_frame_error = ferr_q;
  assign o_busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer: one instance at 16 clocks/bit for
// framing, glitch, back-to-back and reset cases, one at 32 clocks/bit for
// baud-mismatch tolerance. Expected bytes go into per-instance queues when a
// frame is sent and are popped when o_valid is seen.
module tb_uart_rx_deserializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx16, rx32;
  logic [7:0] d16, d32;
  logic       v16, v32, fe16, fe32, b16, b32;

  always #5 clk = ~clk;

  uart_rx_deserializer #(.CLKS_PER_BIT(16)) dut16 (
    .i_clk(clk), .i_reset(rst), .i_rx_unsafe(rx16),
    .o_data(d16), .o_valid(v16), .o_frame_error(fe16), .o_busy(b16)
  );

  uart_rx_deserializer #(.CLKS_PER_BIT(32)) dut32 (
    .i_clk(clk), .i_reset(rst), .i_rx_unsafe(rx32),
    .o_data(d32), .o_valid(v32), .o_frame_error(fe32), .o_busy(b32)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp16[$];
  logic [7:0] exp32[$];

  int   nval16 = 0, nval32 = 0, nfe16 = 0, nfe32 = 0, both_hi = 0;
  int   last_v16 = -1, prev_v16 = -1, last_fe16 = -1;
  int   rise16 = -1, fall16 = -1;
  logic pb16 = 1'b0;

  int t_e, n0, f0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  // Advance one clock and sample all outputs 1 time unit after the edge.
  task automatic step();
    logic [7:0] e;
    @(posedge clk);
    #1;
    if (v16) begin
      nval16++;
      prev_v16 = last_v16;
      last_v16 = cyc;
      chk("sb16_pending", 32'(exp16.size() != 0), 32'd1);
      if (exp16.size() != 0) begin
        e = exp16.pop_front();
        chk("sb16_data", 32'(d16), 32'(e));
      end
    end
    if (v32) begin
      nval32++;
      chk("sb32_pending", 32'(exp32.size() != 0), 32'd1);
      if (exp32.size() != 0) begin
        e = exp32.pop_front();
        chk("sb32_data", 32'(d32), 32'(e));
      end
    end
    if (fe16) begin
      nfe16++;
      last_fe16 = cyc;
    end
    if (fe32) nfe32++;
    if ((v16 && fe16) || (v32 && fe32)) both_hi++;
    if (b16 && !pb16) rise16 = cyc;
    if (!b16 && pb16) fall16 = cyc;
    pb16 = b16;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  // Drive one 8N1 frame (start, 8 data LSB first, stop) with len cycles per bit.
  task automatic send(input int sel, input logic [7:0] b, input logic stopb, input int len);
    logic [9:0] fr;
    fr = {stopb, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (sel == 16) rx16 = fr[i];
      else           rx32 = fr[i];
      repeat (len) step();
    end
  endtask

  initial begin
    logic [7:0] pb;
    rst  = 1'b1;
    rx16 = 1'b1;
    rx32 = 1'b1;
    idle(3);
    chk("rst_busy16", 32'(b16), 32'd0);
    chk("rst_data16", 32'(d16), 32'h00);
    chk("rst_valid16", 32'(v16), 32'd0);
    chk("rst_ferr16", 32'(fe16), 32'd0);
    chk("rst_busy32", 32'(b32), 32'd0);
    chk("rst_data32", 32'(d32), 32'h00);
    rst = 1'b0;
    idle(10);

    // Clean frame 0xA5: pin falls after edge t_e, so t0 = t_e + 2.
    t_e = cyc; n0 = nval16; f0 = nfe16;
    exp16.push_back(8'hA5);
    send(16, 8'hA5, 1'b1, 16);
    rx16 = 1'b1;
    idle(10);
    chk("clean_count", 32'(nval16 - n0), 32'd1);
    chk("clean_when", 32'(last_v16), 32'(t_e + 154));
    chk("clean_ferr", 32'(nfe16 - f0), 32'd0);
    chk("clean_busy_rise", 32'(rise16), 32'(t_e + 3));
    chk("clean_busy_fall", 32'(fall16), 32'(t_e + 154));

    // Glitch: 3 low cycles is a false start, busy t0+1..t0+7.
    t_e = cyc; n0 = nval16; f0 = nfe16;
    rx16 = 1'b0;
    idle(3);
    rx16 = 1'b1;
    idle(30);
    chk("glitch_count", 32'(nval16 - n0), 32'd0);
    chk("glitch_ferr", 32'(nfe16 - f0), 32'd0);
    chk("glitch_busy_rise", 32'(rise16), 32'(t_e + 3));
    chk("glitch_busy_fall", 32'(fall16), 32'(t_e + 10));

    // Framing error: 0x3C with stop low, line then held low 20 bit times.
    t_e = cyc; n0 = nval16; f0 = nfe16;
    send(16, 8'h3C, 1'b0, 16);
    idle(20 * 16);
    chk("ferr_count", 32'(nfe16 - f0), 32'd1);
    chk("ferr_when", 32'(last_fe16), 32'(t_e + 154));
    chk("ferr_no_valid", 32'(nval16 - n0), 32'd0);
    chk("ferr_data_held", 32'(d16), 32'hA5);
    chk("ferr_wait_high_busy", 32'(b16), 32'd1);
    rx16 = 1'b1;
    idle(10);
    chk("ferr_recover_idle", 32'(b16), 32'd0);
    n0 = nval16;
    exp16.push_back(8'h81);
    send(16, 8'h81, 1'b1, 16);
    rx16 = 1'b1;
    idle(10);
    chk("after_ferr_count", 32'(nval16 - n0), 32'd1);

    // Back-to-back 0x00 then 0xFF with no idle gap.
    t_e = cyc; n0 = nval16;
    exp16.push_back(8'h00);
    exp16.push_back(8'hFF);
    send(16, 8'h00, 1'b1, 16);
    send(16, 8'hFF, 1'b1, 16);
    rx16 = 1'b1;
    idle(10);
    chk("b2b_count", 32'(nval16 - n0), 32'd2);
    chk("b2b_spacing", 32'(last_v16 - prev_v16), 32'd160);
    chk("b2b_when", 32'(last_v16), 32'(t_e + 160 + 154));

    // Reset during data bit 4 of a 0x5A frame.
    n0 = nval16; f0 = nfe16;
    pb = 8'h5A;
    rx16 = 1'b0;
    idle(16);
    for (int i = 0; i < 4; i++) begin
      rx16 = pb[i];
      idle(16);
    end
    rx16 = pb[4];
    idle(8);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_busy", 32'(b16), 32'd0);
    chk("midrst_data", 32'(d16), 32'h00);
    chk("midrst_valid", 32'(v16), 32'd0);
    chk("midrst_ferr", 32'(fe16), 32'd0);
    rx16 = 1'b1;
    idle(40);
    chk("midrst_no_strobe", 32'(nval16 - n0), 32'd0);
    chk("midrst_no_ferr", 32'(nfe16 - f0), 32'd0);
    exp16.push_back(8'h5A);
    send(16, 8'h5A, 1'b1, 16);
    rx16 = 1'b1;
    idle(10);
    chk("after_rst_count", 32'(nval16 - n0), 32'd1);

    // Baud tolerance: 32 clocks/bit receiver, transmitter at +3% then -3%.
    n0 = nval32; f0 = nfe32;
    exp32.push_back(8'h55);
    send(32, 8'h55, 1'b1, 33);
    rx32 = 1'b1;
    idle(40);
    exp32.push_back(8'hC3);
    send(32, 8'hC3, 1'b1, 31);
    rx32 = 1'b1;
    idle(40);
    chk("tol_count", 32'(nval32 - n0), 32'd2);
    chk("tol_ferr", 32'(nfe32 - f0), 32'd0);

    chk("never_both_strobes", 32'(both_hi), 32'd0);
    chk("sb16_drained", 32'(exp16.size()), 32'd0);
    chk("sb32_drained", 32'(exp32.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
